// File: rtl/xsm_pkg.sv
// rtl/xsm_pkg.sv - shared constants and FSM state type for the xsm frame path
// Purpose: channel count, sample width and frame-builder state encoding shared
//          by the frame builder and the sink-side processor.
package xsm_pkg;

  localparam int XSM_NUM_CH = 8;
  localparam int XSM_DATA_W = 32;
  localparam int XSM_CH_W   = 3;

  typedef enum logic [1:0] {
    XSM_IDLE    = 2'd0,
    XSM_COLLECT = 2'd1,
    XSM_PUBLISH = 2'd2
  } xsm_fb_state_t;

endpackage

// File: rtl/xsm_sat_counter.sv
// rtl/xsm_sat_counter.sv - saturating event counter
// Purpose: counts enable pulses and sticks at all-ones.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-high reset, clears the count
//   i_inc   in  increment request for this cycle
//   o_count out current count (W bits)
module xsm_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/xsm_frame_builder.sv
// rtl/xsm_frame_builder.sv - collects per-channel samples into published frames
// Purpose: stages one sample per enabled channel and publishes the frame when
//          every channel of the latched mask is staged, or on timeout.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   chan_mask[7:0]       enabled channels, latched when a frame starts
//   s_valid/s_ready      sample handshake; s_chan[2:0], s_data[31:0] payload
//   xsm_valid[7:0]       one-cycle pulse, channels present in the published frame
//   xsm_data0..7[31:0]   published values, held until the next publish
//   frame_partial        last publish was caused by timeout
//   frame_count[15:0]    published frames (wrapping)
//   drop_count[7:0]      samples to masked channels (saturating)
//   ovwr_count[7:0]      staged samples overwritten before publish (saturating)
module xsm_frame_builder
  import xsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XSM_NUM_CH-1:0] chan_mask,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [XSM_CH_W-1:0]   s_chan,
  input  logic [XSM_DATA_W-1:0] s_data,
  output logic [XSM_NUM_CH-1:0] xsm_valid,
  output logic [XSM_DATA_W-1:0] xsm_data0,
  output logic [XSM_DATA_W-1:0] xsm_data1,
  output logic [XSM_DATA_W-1:0] xsm_data2,
  output logic [XSM_DATA_W-1:0] xsm_data3,
  output logic [XSM_DATA_W-1:0] xsm_data4,
  output logic [XSM_DATA_W-1:0] xsm_data5,
  output logic [XSM_DATA_W-1:0] xsm_data6,
  output logic [XSM_DATA_W-1:0] xsm_data7,
  output logic                  frame_partial,
  output logic [15:0]           frame_count,
  output logic [7:0]            drop_count,
  output logic [7:0]            ovwr_count
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  xsm_fb_state_t r_state;
  xsm_fb_state_t w_next;

  logic [XSM_NUM_CH-1:0] r_mask;
  logic [XSM_NUM_CH-1:0] r_staged;
  logic [XSM_NUM_CH-1:0] r_xsm_valid;
  logic [XSM_DATA_W-1:0] r_stage    [XSM_NUM_CH];
  logic [XSM_DATA_W-1:0] r_xsm_data [XSM_NUM_CH];
  logic [15:0]           r_timer;
  logic [15:0]           r_frame_count;
  logic                  r_partial_pend;
  logic                  r_frame_partial;

  logic                  w_s_ready;
  logic                  w_hs;
  logic                  w_enabled;
  logic                  w_drop;
  logic                  w_ovwr;
  logic                  w_complete;
  logic                  w_timeout;
  logic [XSM_NUM_CH-1:0] w_ch_bit;
  logic [XSM_NUM_CH-1:0] w_mask_eff;
  logic [XSM_NUM_CH-1:0] w_wr_bits;

  assign w_s_ready = (r_state != XSM_PUBLISH);
  assign w_hs      = s_valid & w_s_ready;

  // Sample decode. In IDLE no mask is latched yet, so the live chan_mask
  // decides whether the sample opens a frame or is dropped.
  always_comb begin
    w_ch_bit         = '0;
    w_ch_bit[s_chan] = 1'b1;
    w_mask_eff       = (r_state == XSM_IDLE) ? chan_mask : r_mask;
    w_enabled        = w_hs && ((w_ch_bit & w_mask_eff) != '0);
    w_drop           = w_hs && ((w_ch_bit & w_mask_eff) == '0);
    w_ovwr           = w_enabled && (r_state == XSM_COLLECT) && ((r_staged & w_ch_bit) != '0);
    w_wr_bits        = w_enabled ? w_ch_bit : '0;
    // The completing sample counts toward completion in its own cycle.
    w_complete       = (r_state == XSM_COLLECT) && ((r_staged | w_wr_bits) == r_mask);
    w_timeout        = (r_state == XSM_COLLECT) && (r_timer == TMO_LAST);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      XSM_IDLE:    if (w_enabled) w_next = XSM_COLLECT;
      XSM_COLLECT: if (w_complete || w_timeout) w_next = XSM_PUBLISH;
      XSM_PUBLISH: w_next = XSM_IDLE;
      default:     w_next = XSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= XSM_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask          <= '0;
      r_staged        <= '0;
      r_xsm_valid     <= '0;
      r_timer         <= '0;
      r_frame_count   <= '0;
      r_partial_pend  <= 1'b0;
      r_frame_partial <= 1'b0;
      for (int i = 0; i < XSM_NUM_CH; i++) begin
        r_stage[i]    <= '0;
        r_xsm_data[i] <= '0;
      end
    end else begin
      r_xsm_valid <= '0;

      if ((r_state == XSM_IDLE) && w_enabled) begin
        r_mask  <= chan_mask;
        r_timer <= '0;
      end else if (r_state == XSM_COLLECT) begin
        r_timer <= r_timer + 16'd1;
      end

      if (w_enabled) begin
        r_stage[s_chan] <= s_data;
        r_staged        <= r_staged | w_ch_bit;
      end

      // Completion wins over a simultaneous timeout.
      if ((r_state == XSM_COLLECT) && (w_next == XSM_PUBLISH)) begin
        r_partial_pend <= !w_complete;
      end

      if (r_state == XSM_PUBLISH) begin
        for (int i = 0; i < XSM_NUM_CH; i++) begin
          if (r_staged[i]) r_xsm_data[i] <= r_stage[i];
        end
        r_xsm_valid     <= r_staged;
        r_frame_partial <= r_partial_pend;
        r_frame_count   <= r_frame_count + 16'd1;
        r_staged        <= '0;
      end
    end
  end

  xsm_sat_counter #(.W(8)) u_drop_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_drop),
    .o_count (drop_count)
  );

  xsm_sat_counter #(.W(8)) u_ovwr_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_ovwr),
    .o_count (ovwr_count)
  );

  assign s_ready       = w_s_ready;
  assign xsm_valid     = r_xsm_valid;
  assign frame_partial = r_frame_partial;
  assign frame_count   = r_frame_count;
  assign xsm_data0     = r_xsm_data[0];
  assign xsm_data1     = r_xsm_data[1];
  assign xsm_data2     = r_xsm_data[2];
  assign xsm_data3     = r_xsm_data[3];
  assign xsm_data4     = r_xsm_data[4];
  assign xsm_data5     = r_xsm_data[5];
  assign xsm_data6     = r_xsm_data[6];
  assign xsm_data7     = r_xsm_data[7];

endmodule

// File: tb/tb_xsm_frame_builder.sv
// tb/tb_xsm_frame_builder.sv - self-checking bench for xsm_frame_builder
module tb_xsm_frame_builder;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  chan_mask = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [2:0]  s_chan = 3'd0;
  logic [31:0] s_data = 32'd0;
  logic [7:0]  xsm_valid;
  logic [31:0] xsm_data0, xsm_data1, xsm_data2, xsm_data3;
  logic [31:0] xsm_data4, xsm_data5, xsm_data6, xsm_data7;
  logic        frame_partial;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;
  logic [7:0]  ovwr_count;
  logic [31:0] d_out [8];

  assign d_out[0] = xsm_data0;
  assign d_out[1] = xsm_data1;
  assign d_out[2] = xsm_data2;
  assign d_out[3] = xsm_data3;
  assign d_out[4] = xsm_data4;
  assign d_out[5] = xsm_data5;
  assign d_out[6] = xsm_data6;
  assign d_out[7] = xsm_data7;

  xsm_frame_builder #(.TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .chan_mask     (chan_mask),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_chan        (s_chan),
    .s_data        (s_data),
    .xsm_valid     (xsm_valid),
    .xsm_data0     (xsm_data0),
    .xsm_data1     (xsm_data1),
    .xsm_data2     (xsm_data2),
    .xsm_data3     (xsm_data3),
    .xsm_data4     (xsm_data4),
    .xsm_data5     (xsm_data5),
    .xsm_data6     (xsm_data6),
    .xsm_data7     (xsm_data7),
    .frame_partial (frame_partial),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .ovwr_count    (ovwr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a frame is "open" from its first accepted sample, closes
  // when every latched channel has a value or after TMO collecting cycles,
  // then takes one publish cycle during which input is refused.
  bit          m_open;
  bit          m_pub;
  bit          m_part_pend;
  int          m_ncyc;
  logic [7:0]  m_mask;
  logic [7:0]  m_have;
  logic [31:0] m_val [8];

  logic [7:0]  e_valid;
  logic [7:0]  e_drop;
  logic [7:0]  e_ovwr;
  logic        e_part;
  logic [15:0] e_fc;
  logic [31:0] e_data [8];
  logic        last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_pub = 0; m_part_pend = 0; m_ncyc = 0;
    m_mask = '0; m_have = '0;
    e_valid = '0; e_drop = '0; e_ovwr = '0; e_part = 1'b0; e_fc = '0;
    for (int i = 0; i < 8; i++) begin
      m_val[i]  = '0;
      e_data[i] = '0;
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(xsm_valid), 32'(e_valid));
    chk("partial", 32'(frame_partial), 32'(e_part));
    chk("frame_count", 32'(frame_count), 32'(e_fc));
    chk("drop_count", 32'(drop_count), 32'(e_drop));
    chk("ovwr_count", 32'(ovwr_count), 32'(e_ovwr));
    for (int i = 0; i < 8; i++) chk($sformatf("data%0d", i), d_out[i], e_data[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_valid", 32'(xsm_valid), 32'd0);
    chk("rst_partial", 32'(frame_partial), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ovwr", 32'(ovwr_count), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_data%0d", i), d_out[i], 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, predict, advance, compare everything.
  task automatic cycle(input bit v, input logic [2:0] ch, input logic [31:0] d);
    bit         was_open;
    bit         was_pub;
    logic [7:0] mk;
    logic [7:0] n_valid;
    s_valid = v;
    s_chan  = ch;
    s_data  = d;
    #1;
    last_ready = s_ready;
    was_open = m_open;
    was_pub  = m_pub;
    chk("s_ready", 32'(s_ready), 32'(!was_pub));
    n_valid = '0;
    if (was_pub) begin
      for (int i = 0; i < 8; i++) if (m_have[i]) e_data[i] = m_val[i];
      n_valid = m_have;
      e_part  = m_part_pend;
      e_fc    = e_fc + 16'd1;
      m_have  = '0;
      m_pub   = 0;
    end else if (v) begin
      mk = was_open ? m_mask : chan_mask;
      if (mk[ch]) begin
        if (!was_open) begin
          m_open = 1; m_mask = chan_mask; m_ncyc = 0;
        end else if (m_have[ch] && e_ovwr != 8'hFF) begin
          e_ovwr = e_ovwr + 8'd1;
        end
        m_have[ch] = 1'b1;
        m_val[ch]  = d;
      end else if (e_drop != 8'hFF) begin
        e_drop = e_drop + 8'd1;
      end
    end
    if (was_open) begin
      m_ncyc++;
      if (m_have == m_mask) begin
        m_open = 0; m_pub = 1; m_part_pend = 0;
      end else if (m_ncyc == TMO) begin
        m_open = 0; m_pub = 1; m_part_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    e_valid = n_valid;
    check_all();
  endtask

  initial begin
    int waited;
    int pulses;
    int len;
    int gap;
    model_reset();
    #2;
    do_reset();

    // Full frame on all eight channels.
    chan_mask = 8'hFF;
    for (int c = 0; c < 8; c++) cycle(1, 3'(c), 32'h100 + 32'(c));
    chk("full_n1_valid", 32'(xsm_valid), 32'h00);
    cycle(0, 3'd0, 32'd0);
    chk("full_valid", 32'(xsm_valid), 32'hFF);
    chk("full_data3", d_out[3], 32'h103);
    chk("full_fc", 32'(frame_count), 32'd1);
    chk("full_partial", 32'(frame_partial), 32'd0);
    cycle(0, 3'd0, 32'd0);
    chk("full_pulse_end", 32'(xsm_valid), 32'h00);

    // Partial frame released by timeout.
    chan_mask = 8'h0F;
    cycle(1, 3'd0, 32'hA);
    cycle(1, 3'd1, 32'hB);
    waited = 0;
    while (xsm_valid == 8'h00 && waited < 40) begin
      cycle(0, 3'd0, 32'd0);
      waited++;
    end
    chk("tmo_wait", 32'(waited), 32'd16);
    chk("tmo_valid", 32'(xsm_valid), 32'h03);
    chk("tmo_partial", 32'(frame_partial), 32'd1);
    chk("tmo_data2", d_out[2], 32'h102);
    chk("tmo_data0", d_out[0], 32'hA);
    cycle(0, 3'd0, 32'd0);

    // Overwrite before publish.
    chan_mask = 8'h03;
    cycle(1, 3'd0, 32'd1);
    cycle(1, 3'd0, 32'd2);
    cycle(1, 3'd1, 32'd3);
    cycle(0, 3'd0, 32'd0);
    chk("ovw_count", 32'(ovwr_count), 32'd1);
    chk("ovw_data0", d_out[0], 32'd2);
    chk("ovw_data1", d_out[1], 32'd3);
    chk("ovw_valid", 32'(xsm_valid), 32'h03);
    chk("ovw_partial", 32'(frame_partial), 32'd0);
    cycle(0, 3'd0, 32'd0);

    // Back-pressure for exactly the publish cycle.
    cycle(1, 3'd0, 32'h21);
    cycle(1, 3'd1, 32'h22);
    chk("bp_before", 32'(last_ready), 32'd1);
    cycle(1, 3'd0, 32'h23);
    chk("bp_publish", 32'(last_ready), 32'd0);
    cycle(1, 3'd0, 32'h23);
    chk("bp_after", 32'(last_ready), 32'd1);
    chk("bp_pulse1", d_out[0], 32'h21);
    cycle(1, 3'd1, 32'h24);
    cycle(0, 3'd0, 32'd0);
    chk("bp_valid2", 32'(xsm_valid), 32'h03);
    chk("bp_data0", d_out[0], 32'h23);
    cycle(0, 3'd0, 32'd0);

    // Drop saturation on a masked channel.
    chan_mask = 8'h01;
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      cycle(1, 3'd5, $urandom);
      if (xsm_valid != 8'h00) pulses++;
    end
    chk("drop_sat", 32'(drop_count), 32'd255);
    chk("drop_pulses", 32'(pulses), 32'd0);
    chk("drop_fc", 32'(frame_count), 32'd5);
    chk("drop_ready", 32'(s_ready), 32'd1);

    // Reset in the middle of a frame.
    chan_mask = 8'hFF;
    cycle(1, 3'd0, 32'h31);
    cycle(1, 3'd1, 32'h32);
    cycle(1, 3'd2, 32'h33);
    do_reset();
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 3'd0, 32'd0);
      if (xsm_valid != 8'h00) pulses++;
    end
    chk("rstmid_pulses", 32'(pulses), 32'd0);
    for (int c = 0; c < 8; c++) cycle(1, 3'(c), 32'h200 + 32'(c));
    cycle(0, 3'd0, 32'd0);
    chk("rstmid_valid", 32'(xsm_valid), 32'hFF);
    chk("rstmid_fc", 32'(frame_count), 32'd1);
    chk("rstmid_data7", d_out[7], 32'h207);
    cycle(0, 3'd0, 32'd0);

    // Randomized traffic, including mask changes mid-frame and resets.
    for (int it = 0; it < 40; it++) begin
      chan_mask = 8'($urandom);
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 7) == 0) chan_mask = 8'($urandom);
        cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom);
      end
      gap = $urandom_range(0, 20);
      for (int k = 0; k < gap; k++) cycle(0, 3'd0, 32'd0);
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
